// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
package ram_arb_pkg;

    // Default geometry: 8 words of 8 bits
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    // Identifies a requester; used for last_grant and for tagging read returns
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

    // Port that owns the access, given the two win flags (a has precedence)
    function automatic port_sel_e winner_sel(input logic a_win, input logic b_win,
                                             input port_sel_e keep);
        port_sel_e sel;
        sel = keep;
        if (a_win) begin
            sel = PORT_A;
        end else if (b_win) begin
            sel = PORT_B;
        end
        return sel;
    endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM: synchronous write, registered read with one cycle latency.
// Contents are not reset; read data holds until the next read.
module single_port_ram #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk_pi,
    input  logic              en_i,
    input  logic              we_pi,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array: one access per cycle, write or registered read
    always_ff @(posedge clk_pi) begin
        if (en_i) begin
            if (we_pi) begin
                mem[addr_i] <= data_i;
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two requesters (a, b) sharing one single-port RAM.
// Grants are combinational; one access per cycle; reads return one cycle later
// tagged with the requesting port.
// Build option: define ARB_ROUND_ROBIN_EN for alternating winners under
// contention; otherwise port a has fixed priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_pi,
    input  logic              rst_ni,

    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_gnt_o,
    output logic              a_rvalid_o,
    output logic [DATA_W-1:0] a_rdata_o,

    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_gnt_o,
    output logic              b_rvalid_o,
    output logic [DATA_W-1:0] b_rdata_o
);

    port_sel_e         last_grant;
    port_sel_e         last_grant_nxt;
    logic              a_win;
    logic              b_win;

    logic              ram_en_p0;
    logic              ram_we_p0;
    logic [ADDR_W-1:0] ram_addr_p0;
    logic [DATA_W-1:0] ram_data_p0;
    logic [DATA_W-1:0] ram_rdata_p1;

    logic              vld_p1;
    port_sel_e         tag_p1;
    logic [DATA_W-1:0] a_rdata_hold;
    logic [DATA_W-1:0] b_rdata_hold;

    // Arbitration: pick the winner and the next last_grant value
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (rst_ni) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (a_req_i && b_req_i) begin
                a_win = (last_grant == PORT_B);
                b_win = (last_grant == PORT_A);
            end else begin
                a_win = a_req_i;
                b_win = b_req_i;
            end
`else
            a_win = a_req_i;
            b_win = b_req_i && !a_req_i;
`endif
        end
        last_grant_nxt = winner_sel(a_win, b_win, last_grant);
    end

    assign a_gnt_o = a_win;
    assign b_gnt_o = b_win;

    // Stage 0: route the winner's command to the RAM
    assign ram_en_p0   = a_win || b_win;
    assign ram_we_p0   = a_win ? a_we_i   : b_we_i;
    assign ram_addr_p0 = a_win ? a_addr_i : b_addr_i;
    assign ram_data_p0 = a_win ? a_data_i : b_data_i;

    // Arbitration state: remembers the port of the last accepted access
    always_ff @(posedge clk_pi or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= PORT_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    single_port_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_pi  (clk_pi),
        .en_i    (ram_en_p0),
        .we_pi   (ram_we_p0),
        .addr_i  (ram_addr_p0),
        .data_i  (ram_data_p0),
        .rdata_o (ram_rdata_p1)
    );

    // Stage 1: tag each accepted read so its data returns to the right port
    always_ff @(posedge clk_pi or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            tag_p1 <= PORT_A;
        end else begin
            vld_p1 <= ram_en_p0 && !ram_we_p0;
            tag_p1 <= a_win ? PORT_A : PORT_B;
        end
    end

    assign a_rvalid_o = vld_p1 && (tag_p1 == PORT_A);
    assign b_rvalid_o = vld_p1 && (tag_p1 == PORT_B);

    // Per-port copy of the last returned word, so each port's rdata holds
    // while the other port is reading
    always_ff @(posedge clk_pi or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_hold <= '0;
            b_rdata_hold <= '0;
        end else begin
            if (a_rvalid_o) begin
                a_rdata_hold <= ram_rdata_p1;
            end
            if (b_rvalid_o) begin
                b_rdata_hold <= ram_rdata_p1;
            end
        end
    end

    assign a_rdata_o = a_rvalid_o ? ram_rdata_p1 : a_rdata_hold;
    assign b_rdata_o = b_rvalid_o ? ram_rdata_p1 : b_rdata_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
// Honors ARB_ROUND_ROBIN_EN the same way as the design.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk_pi = 1'b0;
    logic              rst_ni;
    logic              a_req_i, a_we_i, b_req_i, b_we_i;
    logic [ADDR_W-1:0] a_addr_i, b_addr_i;
    logic [DATA_W-1:0] a_data_i, b_data_i;
    logic              a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
    logic [DATA_W-1:0] a_rdata_o, b_rdata_o;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_pi     (clk_pi),
        .rst_ni     (rst_ni),
        .a_req_i    (a_req_i),
        .a_we_i     (a_we_i),
        .a_addr_i   (a_addr_i),
        .a_data_i   (a_data_i),
        .a_gnt_o    (a_gnt_o),
        .a_rvalid_o (a_rvalid_o),
        .a_rdata_o  (a_rdata_o),
        .b_req_i    (b_req_i),
        .b_we_i     (b_we_i),
        .b_addr_i   (b_addr_i),
        .b_data_i   (b_data_i),
        .b_gnt_o    (b_gnt_o),
        .b_rvalid_o (b_rvalid_o),
        .b_rdata_o  (b_rdata_o)
    );

    always #5 clk_pi = ~clk_pi;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_last;          // 0 = a won last, 1 = b won last
    bit                m_pa, m_pb;      // read return due this cycle
    logic [DATA_W-1:0] m_pa_d, m_pb_d;
    logic [DATA_W-1:0] m_ha, m_hb;      // last data each port has seen
    bit                a_acc_seen, b_acc_seen;
    bit                ea, eb;

    // Compare DUT against the model mid-cycle, then advance the model
    always @(negedge clk_pi) begin
        if (!rst_ni) begin
            check("rst_a_gnt",    32'(a_gnt_o),    32'd0);
            check("rst_b_gnt",    32'(b_gnt_o),    32'd0);
            check("rst_a_rvalid", 32'(a_rvalid_o), 32'd0);
            check("rst_b_rvalid", 32'(b_rvalid_o), 32'd0);
            check("rst_a_rdata",  32'(a_rdata_o),  32'd0);
            check("rst_b_rdata",  32'(b_rdata_o),  32'd0);
            m_last = 1; m_pa = 0; m_pb = 0; m_ha = '0; m_hb = '0;
            a_acc_seen = 0; b_acc_seen = 0;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            ea = a_req_i && (!b_req_i || m_last == 1);
`else
            ea = a_req_i;
`endif
            eb = b_req_i && !ea;
            if (m_pa) m_ha = m_pa_d;
            if (m_pb) m_hb = m_pb_d;
            check("a_gnt",    32'(a_gnt_o),    32'(ea));
            check("b_gnt",    32'(b_gnt_o),    32'(eb));
            check("a_rvalid", 32'(a_rvalid_o), 32'(m_pa));
            check("b_rvalid", 32'(b_rvalid_o), 32'(m_pb));
            check("a_rdata",  32'(a_rdata_o),  32'(m_ha));
            check("b_rdata",  32'(b_rdata_o),  32'(m_hb));
            m_pa = 0; m_pb = 0;
            if (ea) begin
                m_last = 0;
                if (a_we_i) m_mem[a_addr_i] = a_data_i;
                else begin m_pa = 1; m_pa_d = m_mem[a_addr_i]; end
            end else if (eb) begin
                m_last = 1;
                if (b_we_i) m_mem[b_addr_i] = b_data_i;
                else begin m_pb = 1; m_pb_d = m_mem[b_addr_i]; end
            end
            a_acc_seen = a_req_i && a_gnt_o;
            b_acc_seen = b_req_i && b_gnt_o;
        end
    end

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic we, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] d);
        a_req_i = r; a_we_i = we; a_addr_i = ad; a_data_i = d;
    endtask

    task automatic drive_b(input logic r, input logic we, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] d);
        b_req_i = r; b_we_i = we; b_addr_i = ad; b_data_i = d;
    endtask

    logic [3:0] ga, gb;

    initial begin
        rst_ni = 1'b0;
        drive_a(0, 0, '0, '0);
        drive_b(0, 0, '0, '0);
        repeat (3) tick();
        check("lit_rst_a_rdata", 32'(a_rdata_o), 32'd0);
        rst_ni = 1'b1;

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin
            drive_a(1, 1, ADDR_W'(i), DATA_W'(8'h10 + i));
            tick();
        end
        drive_a(0, 0, '0, '0);
        tick();

        // Single requester: write then read back
        drive_a(1, 1, 3'd3, 8'h5A);
        @(negedge clk_pi);
        check("lit_wr_a_gnt", 32'(a_gnt_o), 32'd1);
        tick();
        drive_a(1, 0, 3'd3, 8'h00);
        @(negedge clk_pi);
        check("lit_rd_a_gnt", 32'(a_gnt_o), 32'd1);
        tick();
        drive_a(0, 0, '0, '0);
        @(negedge clk_pi);
        check("lit_rd_a_rvalid", 32'(a_rvalid_o), 32'd1);
        check("lit_rd_a_rdata",  32'(a_rdata_o),  32'h5A);
        check("lit_rd_b_rvalid", 32'(b_rvalid_o), 32'd0);
        tick();

        // Cross-port coherence: b writes, a reads next cycle
        drive_b(1, 1, 3'd7, 8'hC3);
        tick();
        drive_b(0, 0, '0, '0);
        drive_a(1, 0, 3'd7, 8'h00);
        tick();
        drive_a(0, 0, '0, '0);
        @(negedge clk_pi);
        check("lit_coh_a_rvalid", 32'(a_rvalid_o), 32'd1);
        check("lit_coh_a_rdata",  32'(a_rdata_o),  32'hC3);
        tick();

        // Reset lands in the cycle of a granted read
        drive_a(1, 0, 3'd5, 8'h00);
        @(negedge clk_pi);
        check("lit_pre_rst_a_gnt", 32'(a_gnt_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("lit_in_rst_outs",
              32'({a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o, a_rdata_o, b_rdata_o}), 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        drive_a(0, 0, '0, '0);
        @(negedge clk_pi);
        check("lit_post_rst_a_rvalid", 32'(a_rvalid_o), 32'd0);
        tick();

        // Contention straight after reset: a reads 1, b reads 2, four cycles
        drive_a(1, 0, 3'd1, 8'h00);
        drive_b(1, 0, 3'd2, 8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_pi);
            ga[k] = a_gnt_o;
            gb[k] = b_gnt_o;
            tick();
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("lit_rr_a_gnt_seq", 32'(ga), 32'h5);
        check("lit_rr_b_gnt_seq", 32'(gb), 32'hA);
        drive_a(0, 0, '0, '0);
        drive_b(0, 0, '0, '0);
        tick();
`else
        check("lit_fp_a_gnt_seq", 32'(ga), 32'hF);
        check("lit_fp_b_gnt_seq", 32'(gb), 32'h0);
        drive_a(0, 0, '0, '0);
        @(negedge clk_pi);
        check("lit_fp_b_gnt_after_drop", 32'(b_gnt_o), 32'd1);
        tick();
        drive_b(0, 0, '0, '0);
        tick();
`endif
        @(negedge clk_pi);
        check("lit_cont_a_rdata", 32'(a_rdata_o), 32'h11);
        check("lit_cont_b_rdata", 32'(b_rdata_o), 32'h12);
        tick();

        // Random traffic; a pending request is held until it is granted
        for (int c = 0; c < 3000; c++) begin
            if (!(a_req_i && !a_acc_seen)) begin
                drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
            end
            if (!(b_req_i && !b_acc_seen)) begin
                drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
            end
            tick();
        end
        drive_a(0, 0, '0, '0);
        drive_b(0, 0, '0, '0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
